coherence_dir_arbiter: RTL

- Shares one MSI directory (sm_directory) between two cache nodes, each driving an sm_cblock.
- Accepts read-miss, write-miss and write-back requests from the two nodes and serialises them, one transaction at a time.
- Issues one-cycle message pulses to the directory and routes the directory's fetch/invalidate messages to the correct remote node.
- Waits for acknowledgements and signals completion to the requester.

---
 rtl/coherence_dir_arbiter.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/coherence_dir_arbiter.sv
// coherence_dir_arbiter
// Serialises read-miss / write-miss / write-back requests from two cache nodes
// onto a single MSI directory. It sends one-cycle message pulses to the directory,
// forwards the directory's fetch/invalidate messages to the remote node, collects
// the acknowledgements and pulses done to the requester.
// Build option: STRICT_PRIORITY_EN -- node 0 wins every simultaneous request
// (no round-robin, so node 1 can starve).
module coherence_dir_arbiter #(
  parameter int ADDR_W      = 4,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic [1:0]        req,
  input  logic [1:0]        reqType0,
  input  logic [1:0]        reqType1,
  input  logic [ADDR_W-1:0] reqAddr0,
  input  logic [ADDR_W-1:0] reqAddr1,
  output logic [1:0]        grant,
  output logic [1:0]        done,
  output logic              dirReadMiss,
  output logic              dirWriteMiss,
  output logic              dirWriteBack,
  output logic              dirRequester,
  output logic [ADDR_W-1:0] dirAddr,
  input  logic              dirFetch,
  input  logic              dirInvalidate,
  input  logic              dirDataValueReply,
  input  logic [1:0]        sharers,
  output logic [1:0]        fetchOut,
  output logic [1:0]        invalidateOut,
  input  logic [1:0]        nodeAck,
  output logic              busy,
  output logic              timeoutErr,
  output logic [2:0]        currentState
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'b000,
    S_ISSUE    = 3'b001,
    S_WAIT_DIR = 3'b010,
    S_WAIT_ACK = 3'b011,
    S_COMPLETE = 3'b100
  } state_t;

  localparam logic [1:0] MSG_READ_MISS  = 2'b01;
  localparam logic [1:0] MSG_WRITE_MISS = 2'b10;
  localparam logic [1:0] MSG_WRITE_BACK = 2'b11;
  localparam logic [7:0] TMO_LIMIT      = 8'(ACK_TIMEOUT);

  state_t            state;
  logic              owner;
  logic [1:0]        req_type;
  logic [1:0]        pending;
  logic              reply_seen;
  logic [7:0]        tmo_cnt;
`ifndef STRICT_PRIORITY_EN
  logic              last_grant;
`endif

  logic              win_id;
  logic [1:0]        win_type;
  logic [ADDR_W-1:0] win_addr;
  logic [1:0]        owner_oh;
  logic [1:0]        remote_oh;
  logic [1:0]        inv_pend;
  logic [1:0]        ack_left;
  logic              reply_next;
  logic              tmo_hit;

  // Winner selection for a new transaction and the request fields it carries
  always_comb begin
    win_id = 1'b0;
`ifdef STRICT_PRIORITY_EN
    win_id = ~req[0];
`else
    if (req == 2'b11) win_id = ~last_grant;
    else              win_id = req[1] & ~req[0];
`endif
    win_type = win_id ? reqType1 : reqType0;
    win_addr = win_id ? reqAddr1 : reqAddr0;
  end

  // Decodes of the current owner, forward targets and timeout condition
  always_comb begin
    owner_oh     = owner ? 2'b10 : 2'b01;
    remote_oh    = ~owner_oh;
    inv_pend     = sharers & remote_oh;
    ack_left     = pending & ~nodeAck;
    reply_next   = reply_seen | dirDataValueReply;
    tmo_hit      = (tmo_cnt + 8'd1) == TMO_LIMIT;
    currentState = state;
  end

  // Transaction FSM with registered outputs
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state         <= S_IDLE;
      owner         <= 1'b0;
      req_type      <= '0;
      pending       <= '0;
      reply_seen    <= 1'b0;
      tmo_cnt       <= '0;
`ifndef STRICT_PRIORITY_EN
      last_grant    <= 1'b1;
`endif
      grant         <= '0;
      done          <= '0;
      dirReadMiss   <= 1'b0;
      dirWriteMiss  <= 1'b0;
      dirWriteBack  <= 1'b0;
      dirRequester  <= 1'b0;
      dirAddr       <= '0;
      fetchOut      <= '0;
      invalidateOut <= '0;
      busy          <= 1'b0;
      timeoutErr    <= 1'b0;
    end else begin
      dirReadMiss  <= 1'b0;
      dirWriteMiss <= 1'b0;
      dirWriteBack <= 1'b0;
      done         <= '0;
      case (state)
        S_IDLE: begin
          if (req != '0) begin
            owner        <= win_id;
            req_type     <= win_type;
            grant        <= win_id ? 2'b10 : 2'b01;
            dirRequester <= win_id;
            dirAddr      <= win_addr;
            // The message pulse is launched here so it is high exactly during ISSUE
            dirReadMiss  <= (win_type == MSG_READ_MISS);
            dirWriteMiss <= (win_type == MSG_WRITE_MISS);
            dirWriteBack <= (win_type == MSG_WRITE_BACK);
            busy         <= 1'b1;
            state        <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          tmo_cnt    <= '0;
          reply_seen <= 1'b0;
          if (req_type == MSG_READ_MISS || req_type == MSG_WRITE_MISS) begin
            state <= S_WAIT_DIR;
          end else begin
            done  <= owner_oh;
            state <= S_COMPLETE;
          end
        end

        S_WAIT_DIR: begin
          if (tmo_hit) begin
            timeoutErr    <= 1'b1;
            pending       <= '0;
            fetchOut      <= '0;
            invalidateOut <= '0;
            done          <= owner_oh;
            state         <= S_COMPLETE;
          end else if (dirFetch) begin
            pending    <= remote_oh;
            fetchOut   <= remote_oh;
            reply_seen <= dirDataValueReply;
            tmo_cnt    <= '0;
            state      <= S_WAIT_ACK;
          end else if (dirInvalidate && inv_pend != '0) begin
            pending       <= inv_pend;
            invalidateOut <= inv_pend;
            reply_seen    <= dirDataValueReply;
            tmo_cnt       <= '0;
            state         <= S_WAIT_ACK;
          end else if (dirDataValueReply) begin
            // Also covers an invalidate with no remote sharer arriving with the reply
            done  <= owner_oh;
            state <= S_COMPLETE;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end

        S_WAIT_ACK: begin
          if (tmo_hit) begin
            timeoutErr    <= 1'b1;
            pending       <= '0;
            fetchOut      <= '0;
            invalidateOut <= '0;
            done          <= owner_oh;
            state         <= S_COMPLETE;
          end else begin
            pending       <= ack_left;
            fetchOut      <= fetchOut & ~nodeAck;
            invalidateOut <= invalidateOut & ~nodeAck;
            if (ack_left == '0) begin
              tmo_cnt <= '0;
              if (reply_next) begin
                done  <= owner_oh;
                state <= S_COMPLETE;
              end else begin
                reply_seen <= 1'b0;
                state      <= S_WAIT_DIR;
              end
            end else begin
              reply_seen <= reply_next;
              tmo_cnt    <= tmo_cnt + 8'd1;
            end
          end
        end

        S_COMPLETE: begin
`ifndef STRICT_PRIORITY_EN
          last_grant   <= owner;
`endif
          grant        <= '0;
          dirRequester <= 1'b0;
          dirAddr      <= '0;
          busy         <= 1'b0;
          state        <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
